// File: rtl/sp_meas_pkg.sv
// Shared definitions for the stress-pulse measurement sequencer: FSM state
// encoding, default geometry and the adder-tree sum width derivation.
package sp_meas_pkg;

  localparam int SP_N_DEF          = 32;
  localparam int SP_WIDTH_DEF      = 19;
  localparam int SP_WIN_W_DEF      = 16;
  localparam int SP_SETTLE_CYC_DEF = 2;

  // Adder tree over 32 channels grows the per-channel width by five bits.
  function automatic int sp_sum_w(input int width);
    return width + 5;
  endfunction

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_CLEAR   = 3'd1,
    ST_WINDOW  = 3'd2,
    ST_SETTLE  = 3'd3,
    ST_CAPTURE = 3'd4,
    ST_HOLD    = 3'd5
  } sp_state_e;

endpackage

// File: rtl/sp_meas_ctrl_win_timer.sv
// sp_win_timer: loadable down-counter shared by the WINDOW and SETTLE phases.
// term_o flags the last counted cycle (count value of one).
module sp_win_timer #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  input  logic         dec_i,
  output logic         term_o
);

  logic [W-1:0] cnt_q, cnt_d;

  // Load has priority; decrement saturates at zero.
  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (dec_i && (cnt_q != {W{1'b0}})) begin
      cnt_d = cnt_q - {{(W-1){1'b0}}, 1'b1};
    end else begin
      cnt_d = cnt_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= {W{1'b0}};
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign term_o = (cnt_q == {{(W-1){1'b0}}, 1'b1});

endmodule

// File: rtl/sp_meas_ctrl.sv
// sp_meas_ctrl: clear / gate / settle / capture sequencer for the stress-pulse
// counter bank. Define SP_MEAS_AVG_EN to average 2^AVG_LOG2 windows per start.
module sp_meas_ctrl
  import sp_meas_pkg::*;
#(
  parameter int N          = SP_N_DEF,
  parameter int WIDTH      = SP_WIDTH_DEF,
  parameter int SUM_W      = sp_sum_w(WIDTH),
  parameter int WIN_W      = SP_WIN_W_DEF,
  parameter int SETTLE_CYC = SP_SETTLE_CYC_DEF
`ifdef SP_MEAS_AVG_EN
  ,
  parameter int AVG_LOG2   = 2
`endif
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             abort,
  input  logic [WIN_W-1:0] win_len,
  input  logic [N-1:0]     ch_mask,
  input  logic [N-1:0]     wlord_in,
  output logic [N-1:0]     wlord_out,
  output logic             cnt_rst_n,
  input  logic [SUM_W-1:0] sp_sum,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [SUM_W-1:0] res_data,
  output logic             busy,
  output logic             cfg_err
);

  sp_state_e state_q, state_d;

  logic [WIN_W-1:0] win_len_q, win_len_d;
  logic [N-1:0]     ch_mask_q, ch_mask_d;
  logic             win_en_q, win_en_d;
  logic             cnt_rst_n_q, cnt_rst_n_d;
  logic             res_valid_q, res_valid_d;
  logic [SUM_W-1:0] res_data_q, res_data_d;
  logic             busy_q, busy_d;
  logic             cfg_err_q, cfg_err_d;

  logic             start_ok_s, start_bad_s;
  logic             tmr_load_s, tmr_dec_s, tmr_term_s;
  logic [WIN_W-1:0] tmr_val_s;
  logic             last_pass_s;
  logic [SUM_W-1:0] result_s;

  assign start_ok_s  = (state_q == ST_IDLE) && start && !abort && (win_len != {WIN_W{1'b0}});
  assign start_bad_s = (state_q == ST_IDLE) && start && !abort && (win_len == {WIN_W{1'b0}});

  // CLEAR preloads the window length; the last WINDOW cycle reloads the settle count.
  assign tmr_load_s = (state_q == ST_CLEAR) || ((state_q == ST_WINDOW) && tmr_term_s);
  assign tmr_val_s  = (state_q == ST_CLEAR) ? win_len_q : WIN_W'(SETTLE_CYC);
  assign tmr_dec_s  = (state_q == ST_WINDOW) || (state_q == ST_SETTLE);

  sp_win_timer #(
    .W (WIN_W)
  ) u_timer (
    .clk        (clk),
    .rst        (rst),
    .load_i     (tmr_load_s),
    .load_val_i (tmr_val_s),
    .dec_i      (tmr_dec_s),
    .term_o     (tmr_term_s)
  );

`ifdef SP_MEAS_AVG_EN
  logic [AVG_LOG2-1:0]       pass_q, pass_d;
  logic [SUM_W+AVG_LOG2-1:0] acc_q, acc_d, acc_sum_s;

  assign acc_sum_s   = acc_q + {{AVG_LOG2{1'b0}}, sp_sum};
  assign last_pass_s = &pass_q;
  assign result_s    = SUM_W'(acc_sum_s >> AVG_LOG2);

  // Pass counter and accumulator: cleared on accepted start, stepped at each CAPTURE.
  always_comb begin
    pass_d = pass_q;
    acc_d  = acc_q;
    if (abort) begin
      pass_d = {AVG_LOG2{1'b0}};
    end else if (start_ok_s) begin
      pass_d = {AVG_LOG2{1'b0}};
      acc_d  = {(SUM_W+AVG_LOG2){1'b0}};
    end else if (state_q == ST_CAPTURE) begin
      pass_d = pass_q + {{(AVG_LOG2-1){1'b0}}, 1'b1};
      acc_d  = acc_sum_s;
    end else begin
      pass_d = pass_q;
      acc_d  = acc_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pass_q <= {AVG_LOG2{1'b0}};
      acc_q  <= {(SUM_W+AVG_LOG2){1'b0}};
    end else begin
      pass_q <= pass_d;
      acc_q  <= acc_d;
    end
  end
`else
  assign last_pass_s = 1'b1;
  assign result_s    = sp_sum;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state; abort overrides every transition.
  always_comb begin
    state_d = state_q;
    if (abort) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start_ok_s) state_d = ST_CLEAR;
          else            state_d = ST_IDLE;
        end
        ST_CLEAR:  state_d = ST_WINDOW;
        ST_WINDOW: begin
          if (tmr_term_s) state_d = ST_SETTLE;
          else            state_d = ST_WINDOW;
        end
        ST_SETTLE: begin
          if (tmr_term_s) state_d = ST_CAPTURE;
          else            state_d = ST_SETTLE;
        end
        ST_CAPTURE: begin
          if (last_pass_s) state_d = ST_HOLD;
          else             state_d = ST_CLEAR;
        end
        ST_HOLD: begin
          if (res_ready) state_d = ST_IDLE;
          else           state_d = ST_HOLD;
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // Output decode from the next state so every output is a register.
  always_comb begin
    win_en_d    = (state_d == ST_WINDOW);
    cnt_rst_n_d = (state_d != ST_CLEAR);
    res_valid_d = (state_d == ST_HOLD);
    busy_d      = (state_d != ST_IDLE);
    cfg_err_d   = start_bad_s;
    win_len_d   = win_len_q;
    ch_mask_d   = ch_mask_q;
    res_data_d  = res_data_q;
    if (start_ok_s) begin
      win_len_d = win_len;
      ch_mask_d = ch_mask;
    end else begin
      win_len_d = win_len_q;
      ch_mask_d = ch_mask_q;
    end
    if ((state_q == ST_CAPTURE) && last_pass_s && !abort) begin
      res_data_d = result_s;
    end else begin
      res_data_d = res_data_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      win_len_q   <= {WIN_W{1'b0}};
      ch_mask_q   <= {N{1'b0}};
      win_en_q    <= 1'b0;
      cnt_rst_n_q <= 1'b0;
      res_valid_q <= 1'b0;
      res_data_q  <= {SUM_W{1'b0}};
      busy_q      <= 1'b0;
      cfg_err_q   <= 1'b0;
    end else begin
      win_len_q   <= win_len_d;
      ch_mask_q   <= ch_mask_d;
      win_en_q    <= win_en_d;
      cnt_rst_n_q <= cnt_rst_n_d;
      res_valid_q <= res_valid_d;
      res_data_q  <= res_data_d;
      busy_q      <= busy_d;
      cfg_err_q   <= cfg_err_d;
    end
  end

  // Strobes pass straight through; only the enable is registered.
  assign wlord_out = wlord_in & ch_mask_q & {N{win_en_q}};
  assign cnt_rst_n = cnt_rst_n_q;
  assign res_valid = res_valid_q;
  assign res_data  = res_data_q;
  assign busy      = busy_q;
  assign cfg_err   = cfg_err_q;

endmodule

// File: tb/tb_sp_meas_ctrl.sv
// Directed bench for sp_meas_ctrl with a behavioural counter-bank/adder stub.
// Builds with or without SP_MEAS_AVG_EN; expectations adapt to the pass count.
module tb_sp_meas_ctrl;

  localparam int N     = 32;
  localparam int SUM_W = 24;
  localparam int WIN_W = 16;
  localparam int S     = 2;
`ifdef SP_MEAS_AVG_EN
  localparam int PASSES = 4;
`else
  localparam int PASSES = 1;
`endif

  logic             clk = 1'b0;
  logic             rst;
  logic             start, abort, res_ready;
  logic [WIN_W-1:0] win_len;
  logic [N-1:0]     ch_mask, wlord_in, wlord_out;
  logic             cnt_rst_n, res_valid, busy, cfg_err;
  logic [SUM_W-1:0] sp_sum, res_data;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  sp_meas_ctrl dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .abort     (abort),
    .win_len   (win_len),
    .ch_mask   (ch_mask),
    .wlord_in  (wlord_in),
    .wlord_out (wlord_out),
    .cnt_rst_n (cnt_rst_n),
    .sp_sum    (sp_sum),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .res_data  (res_data),
    .busy      (busy),
    .cfg_err   (cfg_err)
  );

  // Counter bank + adder stub: cleared by cnt_rst_n, sums gated strobes.
  logic [SUM_W-1:0] cnt_acc;
  int               clr_seen = 0;
  int               clr_base = 0;
  logic             ovr = 1'b0;

  always @(posedge clk) begin
    if (!cnt_rst_n) cnt_acc <= '0;
    else            cnt_acc <= cnt_acc + SUM_W'($countones(wlord_out));
    if (!cnt_rst_n && !rst) clr_seen <= clr_seen + 1;
  end

  assign sp_sum = ovr ? SUM_W'(100 + clr_seen - clr_base - 1) : cnt_acc;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Issue a start (called just after a negedge) and watch until res_valid.
  task automatic measure(input logic [WIN_W-1:0] w, input logic [N-1:0] mask,
                         output int lat, output int clr, output int act, output int bad);
    win_len = w;
    ch_mask = mask;
    start   = 1'b1;
    lat = 0; clr = 0; act = 0; bad = 0;
    for (int i = 1; i <= 400; i++) begin
      @(negedge clk);
      if (i == 1) start = 1'b0;
      if (!cnt_rst_n) clr++;
      if (wlord_out != '0) begin
        act++;
        if (wlord_out != (wlord_in & mask)) bad++;
      end
      if (res_valid) begin
        lat = i;
        break;
      end
    end
  endtask

  int          lat, clr, act, bad, stab, vcnt;
  logic [31:0] held;

  initial begin
    rst = 1'b1; start = 1'b0; abort = 1'b0; res_ready = 1'b0;
    win_len = '0; ch_mask = '0; wlord_in = '1;
    repeat (3) @(negedge clk);
    check("rst_cnt_rst_n", 32'(cnt_rst_n), 32'd0);
    check("rst_busy",      32'(busy),      32'd0);
    check("rst_res_valid", 32'(res_valid), 32'd0);
    check("rst_res_data",  32'(res_data),  32'd0);
    check("rst_wlord_out", wlord_out,      32'd0);
    check("rst_cfg_err",   32'(cfg_err),   32'd0);
    rst = 1'b0;
    @(negedge clk);
    check("post_rst_cnt_rst_n", 32'(cnt_rst_n), 32'd1);

    // Full-mask 10-cycle window
    measure(16'd10, 32'hFFFF_FFFF, lat, clr, act, bad);
    check("t1_latency",  32'(lat), 32'(PASSES * (10 + S + 2) + 1));
    check("t1_clr_cyc",  32'(clr), 32'(PASSES));
    check("t1_win_cyc",  32'(act), 32'(PASSES * 10));
    check("t1_win_bad",  32'(bad), 32'd0);
    check("t1_res_data", 32'(res_data), 32'd320);

    // Back-pressure in HOLD; a start there must be ignored
    held = 32'(res_data);
    stab = 0;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (i == 5) begin win_len = 16'd7; start = 1'b1; end
      if (i == 7) start = 1'b0;
      if (res_valid && busy && (32'(res_data) == held)) stab++;
    end
    check("hold_stable", 32'(stab), 32'd20);
    res_ready = 1'b1;
    @(negedge clk);
    res_ready = 1'b0;
    check("hs_res_valid", 32'(res_valid), 32'd0);
    check("hs_busy",      32'(busy),      32'd0);
    repeat (3) @(negedge clk);
    check("hold_start_ignored", 32'(busy), 32'd0);

    // Zero-length window rejected
    win_len = '0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("zero_cfg_err",   32'(cfg_err),   32'd1);
    check("zero_busy",      32'(busy),      32'd0);
    check("zero_cnt_rst_n", 32'(cnt_rst_n), 32'd1);
    @(negedge clk);
    check("zero_cfg_err_pulse", 32'(cfg_err), 32'd0);
    check("zero_cnt_rst_n2",    32'(cnt_rst_n), 32'd1);

    // Partial mask, 4-cycle window
    measure(16'd4, 32'h0000_00FF, lat, clr, act, bad);
    check("t3_latency",  32'(lat), 32'(PASSES * (4 + S + 2) + 1));
    check("t3_win_cyc",  32'(act), 32'(PASSES * 4));
    check("t3_win_bad",  32'(bad), 32'd0);
    check("t3_res_data", 32'(res_data), 32'd32);
    res_ready = 1'b1;
    @(negedge clk);
    res_ready = 1'b0;
    check("t3_released", 32'(busy), 32'd0);

    // Abort in the third WINDOW cycle
    win_len = 16'd10;
    ch_mask = 32'hFFFF_FFFF;
    start   = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      @(negedge clk);
      if (i == 1) start = 1'b0;
    end
    check("ab_window_on", wlord_out, 32'hFFFF_FFFF);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check("ab_busy",      32'(busy),      32'd0);
    check("ab_wlord_out", wlord_out,      32'd0);
    check("ab_res_valid", 32'(res_valid), 32'd0);
    vcnt = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (res_valid || busy) vcnt++;
    end
    check("ab_stays_idle", 32'(vcnt), 32'd0);

`ifdef SP_MEAS_AVG_EN
    // Four captures of 100..103 average to 101
    ovr = 1'b1;
    clr_base = clr_seen;
    measure(16'd3, 32'hFFFF_FFFF, lat, clr, act, bad);
    check("avg_latency",  32'(lat), 32'(4 * (3 + S + 2) + 1));
    check("avg_clr_cyc",  32'(clr), 32'd4);
    check("avg_res_data", 32'(res_data), 32'd101);
    res_ready = 1'b1;
    @(negedge clk);
    res_ready = 1'b0;
    ovr = 1'b0;
    check("avg_released", 32'(busy), 32'd0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
